// File: rtl/uart_pkg.sv
// Definitions shared by the UART transmitter and receiver: FSM encoding and frame constants.
// Optional even-parity bit in the transmitter is enabled by defining UART_TX_PARITY_EN.
package uart_pkg;

    localparam int   CLKS_PER_BIT_DEFAULT = 104;  // 12 MHz / 115200 baud
    localparam int   DATA_BITS            = 8;
    localparam logic START_BIT            = 1'b0;
    localparam logic STOP_BIT             = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } uart_state_e;

    function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte buffer for the UART transmitter: synchronous push/pop, full/empty derived from
// extended read/write pointers; also reports the full flag the pointers will have next cycle.
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             i_Clock,
    input  logic             i_Rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_data,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_full_nxt
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    // Extra MSB distinguishes a full buffer from an empty one when the index bits match.
    function automatic logic ptr_full(input logic [AW:0] wr, input logic [AW:0] rd);
        return (wr[AW] != rd[AW]) && (wr[AW-1:0] == rd[AW-1:0]);
    endfunction

    assign o_full     = ptr_full(wr_ptr_q, rd_ptr_q);
    assign o_empty    = (wr_ptr_q == rd_ptr_q);
    assign push_ok    = i_push && !o_full;
    assign pop_ok     = i_pop && !o_empty;
    assign o_pop_data = mem_q[rd_ptr_q[AW-1:0]];
    assign o_full_nxt = ptr_full(wr_ptr_d, rd_ptr_d);

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        // NOTE: sequential state uses non-blocking assignment so all flops update together.
        if (!i_Rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge i_Clock) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= i_push_data;
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// UART transmitter (8N1, LSB first) fed by a small byte FIFO; frames go out back-to-back.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data bit 7 and stop.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       i_Clock,
    input  logic       i_Rst_n,
    input  logic       i_Tx_DV,
    input  logic [7:0] i_Tx_Byte,
    output logic       o_Tx_Ready,
    output logic       o_Tx_Serial,
    output logic       o_Tx_Active,
    output logic       o_Tx_Done
);

    localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        IDX_LAST = 3'(DATA_BITS - 1);

    uart_state_e          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2:0]           idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 serial_q, serial_d;
    logic                 active_q, active_d;
    logic                 done_q, done_d;
    logic                 ready_q, ready_d;

    logic                 bit_end;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic [7:0]           fifo_rd_data;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_full_nxt;

    assign fifo_push = i_Tx_DV && ready_q && !fifo_full;
    assign bit_end   = (cnt_q == CNT_LAST);

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .i_Clock     (i_Clock),
        .i_Rst_n     (i_Rst_n),
        .i_push      (fifo_push),
        .i_push_data (i_Tx_Byte),
        .i_pop       (fifo_pop),
        .o_pop_data  (fifo_rd_data),
        .o_full      (fifo_full),
        .o_empty     (fifo_empty),
        .o_full_nxt  (fifo_full_nxt)
    );

    // Next-state logic; outputs are derived from the next state so the registers line up with it.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        fifo_pop = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = START;
                    cnt_d    = '0;
                end
            end
            START: begin
                cnt_d = bit_end ? '0 : cnt_q + 1'b1;
                if (bit_end) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                cnt_d = bit_end ? '0 : cnt_q + 1'b1;
                if (bit_end) begin
                    // Rotate rather than shift: after eight bits the byte is intact again for parity.
                    idx_d   = idx_q + 1'b1;
                    shift_d = {shift_q[0], shift_q[DATA_BITS-1:1]};
                    if (idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                cnt_d = bit_end ? '0 : cnt_q + 1'b1;
                if (bit_end) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                cnt_d = bit_end ? '0 : cnt_q + 1'b1;
                if (bit_end) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        state_d  = START;
                    end else begin
                        state_d  = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase

        if (fifo_pop) begin
            shift_d = fifo_rd_data;
        end

        case (state_d)
            START:   serial_d = START_BIT;
            DATA:    serial_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  serial_d = even_parity(shift_d);
`endif
            default: serial_d = STOP_BIT;  // idle line and stop bit are both mark level
        endcase

        active_d = (state_d != IDLE);
        done_d   = (state_d == STOP) && (cnt_d == CNT_LAST);
        // Ready reflects the pointers after this edge, so a full FIFO never takes a push.
        ready_d  = !fifo_full_nxt;
    end

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            serial_q <= STOP_BIT;
            active_q <= 1'b0;
            done_q   <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            serial_q <= serial_d;
            active_q <= active_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
        end
    end

    assign o_Tx_Ready  = ready_q;
    assign o_Tx_Serial = serial_q;
    assign o_Tx_Active = active_q;
    assign o_Tx_Done   = done_q;

endmodule
